// File: rtl/register_byte_unloader_pkg.sv
// Shared definitions for the byte-unloader family: the unloader FSM encoding
// and the data-bus byte width used by the bus-side modules.
package register_byte_unloader_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/register_byte_unloader.sv
// Captures a wide register word on Start and emits it MSB byte first over a
// Valid/Ready byte stream. All state and outputs update on the falling clock edge.
module register_byte_unloader
  import register_byte_unloader_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int ByteWidth = BYTE_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [DataWidth-1:0] DIn,
  input  logic                 Ready,
  output logic                 Valid,
  output logic [ByteWidth-1:0] DOut,
  output logic                 Last,
  output logic                 Busy,
  output logic                 Done
);

  localparam int NumBytes  = DataWidth / ByteWidth;
  localparam int IdxWidth  = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int BaseWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

  if ((DataWidth % ByteWidth) != 0 || DataWidth < ByteWidth) begin : g_bad_width
    $error("register_byte_unloader: DataWidth must be a non-zero multiple of ByteWidth");
  end

  // Handshake: a byte transfers on a falling edge where Valid and Ready are
  // both high; DOut and Last are held unchanged while Valid is high and Ready low.

  state_t                r_state, w_state_next;
  logic [DataWidth-1:0]  r_shadow, w_shadow_next;
  logic [IdxWidth-1:0]   r_index, w_index_next;
  logic [ByteWidth-1:0]  r_dout, w_dout_next;
  logic                  r_valid, w_valid_next;
  logic                  r_last, w_last_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;

  logic [DataWidth-1:0]  w_sel_word;
  logic [IdxWidth-1:0]   w_sel_idx;
  logic [BaseWidth-1:0]  w_base;
  logic [ByteWidth-1:0]  w_sel_byte;
  logic                  w_sel_last;

  // The byte to present next: first byte of DIn when loading, otherwise the
  // following byte of the shadow copy.
  assign w_sel_word = (r_state == ST_IDLE) ? DIn : r_shadow;
  assign w_sel_idx  = (r_state == ST_IDLE || r_last) ? '0 : r_index + 1'b1;
  assign w_base     = BaseWidth'(DataWidth - 1)
                    - BaseWidth'(w_sel_idx) * BaseWidth'(ByteWidth);
  assign w_sel_byte = w_sel_word[w_base -: ByteWidth];
  assign w_sel_last = (w_sel_idx == IdxWidth'(NumBytes - 1));

  always_comb begin
    w_state_next  = r_state;
    w_shadow_next = r_shadow;
    w_index_next  = r_index;
    w_dout_next   = r_dout;
    w_valid_next  = r_valid;
    w_last_next   = r_last;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_next  = ST_SEND;
          w_shadow_next = DIn;
          w_index_next  = '0;
          w_busy_next   = 1'b1;
          w_valid_next  = 1'b1;
          w_dout_next   = w_sel_byte;
          w_last_next   = w_sel_last;
        end
      end
      ST_SEND: begin
        if (r_valid && Ready) begin
          if (r_last) begin
            w_state_next = ST_DONE;
            w_valid_next = 1'b0;
            w_last_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_index_next = w_sel_idx;
            w_dout_next  = w_sel_byte;
            w_last_next  = w_sel_last;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
        w_last_next  = 1'b0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_index  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shadow <= w_shadow_next;
      r_index  <= w_index_next;
      r_dout   <= w_dout_next;
      r_valid  <= w_valid_next;
      r_last   <= w_last_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  assign Valid = r_valid;
  assign DOut  = r_dout;
  assign Last  = r_last;
  assign Busy  = r_busy;
  assign Done  = r_done;

endmodule

// File: tb/tb_register_byte_unloader.sv
// Directed bench for register_byte_unloader at 8-, 16- and 32-bit word widths
// with hand-computed byte sequences.
module tb_register_byte_unloader;

  logic clk;
  logic rst;

  logic        s16_start, s16_ready, s16_valid, s16_last, s16_busy, s16_done;
  logic [15:0] s16_din;
  logic [7:0]  s16_dout;
  logic        s8_start, s8_ready, s8_valid, s8_last, s8_busy, s8_done;
  logic [7:0]  s8_din;
  logic [7:0]  s8_dout;
  logic        s32_start, s32_ready, s32_valid, s32_last, s32_busy, s32_done;
  logic [31:0] s32_din;
  logic [7:0]  s32_dout;

  int checks;
  int errors;

  register_byte_unloader #(.DataWidth(16), .ByteWidth(8)) u_dut16 (
    .Clk(clk), .Reset(rst), .Start(s16_start), .DIn(s16_din), .Ready(s16_ready),
    .Valid(s16_valid), .DOut(s16_dout), .Last(s16_last), .Busy(s16_busy), .Done(s16_done)
  );

  register_byte_unloader #(.DataWidth(8), .ByteWidth(8)) u_dut8 (
    .Clk(clk), .Reset(rst), .Start(s8_start), .DIn(s8_din), .Ready(s8_ready),
    .Valid(s8_valid), .DOut(s8_dout), .Last(s8_last), .Busy(s8_busy), .Done(s8_done)
  );

  register_byte_unloader #(.DataWidth(32), .ByteWidth(8)) u_dut32 (
    .Clk(clk), .Reset(rst), .Start(s32_start), .DIn(s32_din), .Ready(s32_ready),
    .Valid(s32_valid), .DOut(s32_dout), .Last(s32_last), .Busy(s32_busy), .Done(s32_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active edge is the falling edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Packs {Valid, Last, Busy, Done, DOut} of the 16-bit instance.
  function automatic logic [11:0] st16();
    return {s16_valid, s16_last, s16_busy, s16_done, s16_dout};
  endfunction

  function automatic logic [11:0] st8();
    return {s8_valid, s8_last, s8_busy, s8_done, s8_dout};
  endfunction

  function automatic logic [11:0] st32();
    return {s32_valid, s32_last, s32_busy, s32_done, s32_dout};
  endfunction

  logic [7:0] exp32 [4];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    s16_start = 0; s16_ready = 0; s16_din = '0;
    s8_start  = 0; s8_ready  = 0; s8_din  = '0;
    s32_start = 0; s32_ready = 0; s32_din = '0;
    tick();
    tick();
    check("reset16", 32'(st16()), 32'h000);
    check("reset8",  32'(st8()),  32'h000);
    check("reset32", 32'(st32()), 32'h000);
    rst = 1'b0;
    tick();
    check("idle16", 32'(st16()), 32'h000);

    // 1: 0xA55A streamed with Ready held high
    s16_ready = 1; s16_start = 1; s16_din = 16'hA55A;
    tick();
    check("t1_b0", 32'(st16()), {20'h0, 4'b1010, 8'hA5});
    s16_start = 0;
    tick();
    check("t1_b1", 32'(st16()), {20'h0, 4'b1110, 8'h5A});
    tick();
    check("t1_done", 32'({s16_valid, s16_last, s16_busy, s16_done}), 32'b0011);
    tick();
    check("t1_idle", 32'({s16_valid, s16_busy, s16_done}), 32'b000);

    // 2: 0x1234 with a three-cycle stall on the first byte
    s16_ready = 0; s16_start = 1; s16_din = 16'h1234;
    tick();
    s16_start = 0;
    check("t2_b0", 32'(st16()), {20'h0, 4'b1010, 8'h12});
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t2_stall%0d", i), 32'(st16()), {20'h0, 4'b1010, 8'h12});
    end
    s16_ready = 1;
    tick();
    check("t2_b1", 32'(st16()), {20'h0, 4'b1110, 8'h34});
    tick();
    check("t2_done", 32'({s16_valid, s16_done}), 32'b01);
    tick();
    check("t2_idle", 32'({s16_busy, s16_done}), 32'b00);

    // 3: Start during SEND and DONE is ignored; a later Start is accepted
    s16_start = 1; s16_din = 16'hC3D4;
    tick();
    check("t3_b0", 32'(st16()), {20'h0, 4'b1010, 8'hC3});
    s16_din = 16'hFFFF;
    tick();
    check("t3_b1", 32'(st16()), {20'h0, 4'b1110, 8'hD4});
    tick();
    check("t3_done", 32'({s16_valid, s16_busy, s16_done}), 32'b011);
    s16_start = 0;
    tick();
    check("t3_idle", 32'({s16_valid, s16_busy, s16_done}), 32'b000);
    s16_start = 1; s16_din = 16'h5678;
    tick();
    s16_start = 0;
    check("t3_n0", 32'(st16()), {20'h0, 4'b1010, 8'h56});
    tick();
    check("t3_n1", 32'(st16()), {20'h0, 4'b1110, 8'h78});
    tick();
    check("t3_ndone", 32'(s16_done), 32'h1);
    tick();

    // 4: asynchronous reset mid-transfer, then a clean transfer
    s16_start = 1; s16_din = 16'hBEEF;
    tick();
    s16_start = 0;
    check("t4_b0", 32'(st16()), {20'h0, 4'b1010, 8'hBE});
    tick();
    check("t4_b1", 32'(st16()), {20'h0, 4'b1110, 8'hEF});
    #2 rst = 1'b1;
    #1;
    check("t4_async", 32'(st16()), 32'h000);
    tick();
    check("t4_nodone", 32'(st16()), 32'h000);
    rst = 1'b0;
    tick();
    check("t4_nodone2", 32'(s16_done), 32'h0);
    s16_start = 1; s16_din = 16'h0102;
    tick();
    s16_start = 0;
    check("t4_c0", 32'(st16()), {20'h0, 4'b1010, 8'h01});
    tick();
    check("t4_c1", 32'(st16()), {20'h0, 4'b1110, 8'h02});
    tick();
    check("t4_cdone", 32'(s16_done), 32'h1);

    // 5: single-byte word
    s8_ready = 1; s8_start = 1; s8_din = 8'h7E;
    tick();
    s8_start = 0;
    check("t5_b0", 32'(st8()), {20'h0, 4'b1110, 8'h7E});
    tick();
    check("t5_done", 32'({s8_valid, s8_last, s8_busy, s8_done}), 32'b0011);
    tick();
    check("t5_idle", 32'({s8_busy, s8_done}), 32'b00);

    // 6: 32-bit word with Ready toggling and DIn disturbed after acceptance
    exp32[0] = 8'hDE; exp32[1] = 8'hAD; exp32[2] = 8'hBE; exp32[3] = 8'hEF;
    s32_ready = 0; s32_start = 1; s32_din = 32'hDEADBEEF;
    tick();
    s32_start = 0;
    s32_din = 32'h00000000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_b%0d", k), 32'(st32()),
            {20'h0, 1'b1, (k == 3), 2'b10, exp32[k]});
      s32_ready = 0;
      tick();
      check($sformatf("t6_hold%0d", k), 32'(st32()),
            {20'h0, 1'b1, (k == 3), 2'b10, exp32[k]});
      s32_ready = 1;
      tick();
    end
    check("t6_done", 32'({s32_valid, s32_last, s32_busy, s32_done}), 32'b0011);
    s32_ready = 0;
    tick();
    check("t6_idle", 32'({s32_busy, s32_done}), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
